// File: rtl/des3_pkg.sv
// Shared types and constants for the Triple-DES CBC chaining controller.
package des3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_OUTPUT = 3'd4
  } ctrl_state_t;

  localparam int   BLOCK_W = 64;
  localparam int   CNT_W   = 16;
  localparam logic DIR_ENC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

endpackage

// File: rtl/des3_cbc_ctrl.sv
// CBC chaining controller: feeds one 64-bit block at a time to a Triple-DES core,
// applies the IV / previous-ciphertext XOR and returns results on an output stream.
module des3_cbc_ctrl
  import des3_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [1:0] MODE_UPPER     = 2'b00
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               decrypt,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_last,
  output logic               core_enable,
  output logic [BLOCK_W-1:0] core_data_in,
  output logic [2:0]         core_mode,
  input  logic               core_data_ready,
  input  logic [BLOCK_W-1:0] core_data_out,
  output logic               busy,
  output logic               error,
  output ctrl_state_t        dbg_state
);

  // Streams: a block moves on a rising edge where valid && ready are both high.
  // A source holds valid and data stable until that edge; ready never depends on valid.

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  ctrl_state_t        state;
  logic [BLOCK_W-1:0] chain;
  logic [BLOCK_W-1:0] ct_save;
  logic               dir;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               timeout_hit;

  assign core_mode = {MODE_UPPER, dir};
  assign dbg_state = state;

  // Wait counter: cleared while the core is being kicked, saturates instead of wrapping.
  always_comb begin
    cnt_next = cnt;
    if (state == ST_ISSUE) begin
      cnt_next = '0;
    end else if (state == ST_WAIT && !core_data_ready && cnt != {CNT_W{1'b1}}) begin
      cnt_next = cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ST_WAIT) && !core_data_ready && (cnt_next >= TIMEOUT_LIM);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      chain        <= '0;
      ct_save      <= '0;
      dir          <= DIR_ENC;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      core_enable  <= 1'b0;
      core_data_in <= '0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      core_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            chain    <= iv;
            dir      <= decrypt;
            error    <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            core_data_in <= (dir == DIR_ENC) ? (in_data ^ chain) : in_data;
            if (dir == DIR_DEC) ct_save <= in_data;
            out_last    <= in_last;
            in_ready    <= 1'b0;
            core_enable <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_data_ready) begin
            if (dir == DIR_ENC) begin
              out_data <= core_data_out;
              chain    <= core_data_out;
            end else begin
              out_data <= core_data_out ^ chain;
              chain    <= ct_save;
            end
            out_valid <= 1'b1;
            state     <= ST_OUTPUT;
          end else if (timeout_hit) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              in_ready <= 1'b1;
              state    <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des3_cbc_ctrl.sv
// Bench for des3_cbc_ctrl: a CBC reference model with a latency-5 inverting core stand-in.
module tb_des3_cbc_ctrl;
  import des3_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [63:0] iv = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_last;
  logic        core_enable;
  logic [63:0] core_data_in;
  logic [2:0]  core_mode;
  logic        core_data_ready;
  logic [63:0] core_data_out;
  logic        busy;
  logic        error;
  ctrl_state_t dbg_state;

  logic        model_ready = 1'b0;
  logic [63:0] model_data = '0;
  logic [63:0] model_hold = '0;
  int          model_cnt = 0;
  bit          core_silent = 1'b0;
  logic        stray_ready = 1'b0;
  logic [63:0] stray_data = '0;

  logic [63:0] exp_q[$];
  logic [63:0] msg[8];
  logic [63:0] model_chain = '0;
  bit          model_dec = 1'b0;
  int          checks = 0;
  int          failures = 0;

  assign core_data_ready = model_ready | stray_ready;
  assign core_data_out   = stray_ready ? stray_data : model_data;

  des3_cbc_ctrl #(.TIMEOUT_CYCLES(TO), .MODE_UPPER(2'b00)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .decrypt(decrypt), .iv(iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_enable(core_enable), .core_data_in(core_data_in), .core_mode(core_mode),
    .core_data_ready(core_data_ready), .core_data_out(core_data_out),
    .busy(busy), .error(error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Core stand-in: answers ~data_in five cycles after the enable cycle.
  always @(posedge clk) begin
    model_ready <= 1'b0;
    if (core_enable && !core_silent) begin
      model_cnt  <= 4;
      model_hold <= ~core_data_in;
    end else if (model_cnt == 1) begin
      model_ready <= 1'b1;
      model_data  <= model_hold;
      model_cnt   <= 0;
    end else if (model_cnt > 1) begin
      model_cnt <= model_cnt - 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input bit dec, input logic [63:0] v);
    start = 1'b1; decrypt = dec; iv = v;
    @(negedge clk);
    start = 1'b0; decrypt = ~dec; iv = 64'($urandom);
    model_dec = dec; model_chain = v;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || error !== 1'b0) begin
      failures++;
      $display("FAIL start_accept: in_ready=%b busy=%b error=%b expected 1 1 0", in_ready, busy, error);
    end
  endtask

  task automatic send_block(input logic [63:0] d, input bit last, output bit ok);
    logic [63:0] cin, res;
    if (!model_dec) begin
      cin = d ^ model_chain; res = ~cin; model_chain = res;
    end else begin
      cin = d; res = (~d) ^ model_chain; model_chain = d;
    end
    exp_q.push_back(res);
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int i = 0; i < 50; i++) begin
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL in_handshake: in_ready never rose (got %b, expected 1)", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0; in_data = 64'($urandom); in_last = 1'($urandom);
    checks++;
    if (core_enable !== 1'b1 || core_data_in !== cin || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL issue: core_enable=%b core_data_in=%h in_ready=%b expected 1 %h 0",
               core_enable, core_data_in, in_ready, cin);
    end
    checks++;
    if (core_mode !== {2'b00, model_dec}) begin
      failures++;
      $display("FAIL core_mode: got %b expected %b", core_mode, {2'b00, model_dec});
    end
  endtask

  task automatic recv_block(input bit last, input int stall);
    logic [63:0] exp;
    bit seen;
    seen = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL exp_queue: got empty queue expected one pending block");
      return;
    end
    exp = exp_q.pop_front();
    out_ready = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL out_valid_wait: out_valid=%b expected 1 within 60 cycles", out_valid);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0 || core_enable !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold: out_valid=%b out_data=%h in_ready=%b core_enable=%b expected 1 %h 0 0",
                 out_valid, out_data, in_ready, core_enable, exp);
      end
    end
    checks++;
    if (out_data !== exp || out_last !== last) begin
      failures++;
      $display("FAIL out_block: out_data=%h out_last=%b expected %h %b", out_data, out_last, exp, last);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== !last || in_ready !== !last) begin
      failures++;
      $display("FAIL after_handshake: out_valid=%b busy=%b in_ready=%b expected 0 %b %b",
               out_valid, busy, in_ready, !last, !last);
    end
  endtask

  task automatic run_msg(input bit dec, input logic [63:0] v, input int n, input int max_stall);
    bit ok;
    do_start(dec, v);
    for (int i = 0; i < n; i++) begin
      send_block(msg[i], (i == n - 1), ok);
      if (!ok) return;
      recv_block((i == n - 1), $urandom_range(0, max_stall));
    end
  endtask

  task automatic test_reset;
    #1 n_rst = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || core_enable !== 1'b0 ||
        busy !== 1'b0 || error !== 1'b0 || out_data !== 64'h0 || core_data_in !== 64'h0 ||
        core_mode !== 3'b000 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_values: rdy=%b ov=%b ol=%b en=%b busy=%b err=%b od=%h cdi=%h mode=%b st=%0d expected all zero",
               in_ready, out_valid, out_last, core_enable, busy, error, out_data, core_data_in, core_mode, dbg_state);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_encrypt_vector;
    msg[0] = 64'h0; msg[1] = 64'hFEDCBA9876543210;
    exp_q.delete();
    run_msg(1'b0, 64'h0123456789ABCDEF, 2, 0);
  endtask

  task automatic test_decrypt_vector;
    msg[0] = 64'hFEDCBA9876543210; msg[1] = 64'hFFFFFFFFFFFFFFFF;
    exp_q.delete();
    run_msg(1'b1, 64'h0123456789ABCDEF, 2, 2);
  endtask

  task automatic test_backpressure;
    bit ok;
    exp_q.delete();
    do_start(1'b0, 64'($urandom));
    send_block(64'($urandom), 1'b0, ok);
    if (ok) recv_block(1'b0, 20);
    send_block(64'($urandom), 1'b1, ok);
    if (ok) recv_block(1'b1, 0);
  endtask

  task automatic test_timeout;
    bit ok;
    exp_q.delete();
    core_silent = 1'b1;
    do_start(1'b0, 64'($urandom));
    send_block(64'($urandom), 1'b1, ok);
    exp_q.delete();
    if (ok) begin
      for (int k = 1; k <= TO; k++) begin
        @(negedge clk);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1 || dbg_state !== ST_WAIT) begin
          failures++;
          $display("FAIL timeout_early: wait cycle %0d error=%b busy=%b state=%0d expected 0 1 WAIT",
                   k, error, busy, dbg_state);
        end
      end
      @(negedge clk);
      checks++;
      if (error !== 1'b1 || busy !== 1'b0 || dbg_state !== ST_IDLE || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL timeout_fire: error=%b busy=%b state=%0d out_valid=%b expected 1 0 IDLE 0",
                 error, busy, dbg_state, out_valid);
      end
    end
    core_silent = 1'b0;
    repeat (3) @(negedge clk);
    msg[0] = 64'($urandom);
    run_msg(1'b1, 64'($urandom), 1, 1);
  endtask

  task automatic test_stray_events;
    bit ok;
    exp_q.delete();
    stray_ready = 1'b1; stray_data = {32'($urandom), 32'($urandom)};
    @(negedge clk);
    stray_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL stray_idle: out_valid=%b state=%0d expected 0 IDLE", out_valid, dbg_state);
    end
    do_start(1'b0, 64'h0123456789ABCDEF);
    send_block(64'h0, 1'b0, ok);
    stray_ready = 1'b1; stray_data = {32'($urandom), 32'($urandom)};
    @(negedge clk);
    stray_ready = 1'b0;
    start = 1'b1; decrypt = 1'b1; iv = 64'($urandom);
    @(negedge clk);
    start = 1'b0;
    if (ok) recv_block(1'b0, 0);
    send_block(64'hFEDCBA9876543210, 1'b1, ok);
    if (ok) recv_block(1'b1, 0);
  endtask

  task automatic test_reset_mid_wait;
    bit ok;
    exp_q.delete();
    do_start(1'b0, 64'($urandom));
    send_block(64'($urandom), 1'b1, ok);
    exp_q.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || core_enable !== 1'b0 ||
        busy !== 1'b0 || error !== 1'b0 || out_data !== 64'h0 || core_data_in !== 64'h0 ||
        core_mode !== 3'b000 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_mid_wait: rdy=%b ov=%b ol=%b en=%b busy=%b err=%b od=%h cdi=%h mode=%b st=%0d expected all zero",
               in_ready, out_valid, out_last, core_enable, busy, error, out_data, core_data_in, core_mode, dbg_state);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL late_result: cycle %0d out_valid=%b busy=%b expected 0 0", i, out_valid, busy);
      end
    end
  endtask

  task automatic test_random;
    int n;
    for (int m = 0; m < 8; m++) begin
      exp_q.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) msg[i] = {32'($urandom), 32'($urandom)};
      run_msg(1'($urandom_range(0, 1)), {32'($urandom), 32'($urandom)}, n, 3);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_encrypt_vector;
    test_decrypt_vector;
    test_backpressure;
    test_timeout;
    test_stray_events;
    test_reset_mid_wait;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des3_cbc_ctrl.md
# des3_cbc_ctrl

CBC chaining controller that sequences the Triple_DES core one block at a time. It accepts 64-bit blocks over a valid/ready stream and applies the CBC XOR with the IV or the previous ciphertext. It issues a one-cycle enable to the core, waits for `data_ready` under a timeout, and returns results over a valid/ready output stream. It sits between the host/DMA stream logic and the Triple_DES instance; key and round-key generation stay in the core.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum WAIT-state cycles before declaring a core fault; range 1..65535.
- `MODE_UPPER`, default 2'b00: constant driven onto `core_mode[2:1]`.
- `clk` in 1: single clock, all logic rising-edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin message; sampled only in IDLE.
- `decrypt` in 1: direction for the message; latched on `start`.
- `iv` in 64: initial chaining value; latched on `start`.
- `in_valid` in 1 / `in_ready` out 1: input block handshake.
- `in_data` in 64, `in_last` in 1: plaintext (encrypt) or ciphertext (decrypt) block, and last-block flag.
- `out_valid` out 1 / `out_ready` in 1: output block handshake.
- `out_data` out 64, `out_last` out 1: result block, and last flag copied from the input.
- `core_enable` out 1: one-cycle pulse to Triple_DES `enable`.
- `core_data_in` out 64: to Triple_DES `data_in`.
- `core_mode` out 3: equals {`MODE_UPPER`, latched decrypt}.
- `core_data_ready` in 1, `core_data_out` in 64: from Triple_DES.
- `busy` out 1: high in every state except IDLE.
- `error` out 1: sticky timeout flag; cleared on accepted `start` or reset.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, OUTPUT.
- IDLE:
  - On `start`: chain ← `iv`, dir ← `decrypt`, error ← 0, go to LOAD.
  - `in_ready` is 0.
- LOAD:
  - `in_ready` = 1.
  - On `in_valid`: latch the block, `in_last`, and `core_data_in`, then go to ISSUE.
  - Encrypt: `core_data_in` = `in_data` XOR chain.
  - Decrypt: `core_data_in` = `in_data`; ct_save ← `in_data`.
- ISSUE:
  - `core_enable` = 1 for exactly this cycle.
  - Timeout counter cleared; go to WAIT.
- WAIT:
  - On `core_data_ready`, compute the result, register it, go to OUTPUT.
    - Encrypt: out ← `core_data_out`; chain ← `core_data_out`.
    - Decrypt: out ← `core_data_out` XOR chain; chain ← ct_save.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES`: error ← 1, go to IDLE, no output produced.
- OUTPUT:
  - `out_valid` = 1, with `out_data` and `out_last` held stable until `out_ready`.
  - On handshake: go to IDLE if last, else go to LOAD.
- `core_data_ready` is ignored outside WAIT, including in the ISSUE cycle.
- `start` is ignored outside IDLE.
- `core_mode` is stable from `start` until IDLE is re-entered.
- The counter width is 16 bits and saturates; there is no wrap-around.

## Timing
- Reset values: `in_ready`, `out_valid`, `out_last`, `core_enable`, `busy`, `error` = 0; `out_data`, `core_data_in` = 0; `core_mode` = {`MODE_UPPER`, 0}; state IDLE; chain and ct_save = 0.
- Reset asserted mid-operation aborts immediately to the reset values. A core result arriving later is ignored because the state is IDLE.
- Cycle sequence for one block:
  - Input handshake in cycle N.
  - `core_enable` high in cycle N+1.
  - WAIT begins in cycle N+2.
  - `core_data_ready` arrives in cycle M (≥ N+2); `out_valid` is high in cycle M+1.
- Throughput is one block in flight. Minimum block period is 4 cycles plus core latency.
- `out_ready` held low stalls indefinitely in OUTPUT; no timeout applies there.
- Timeout: if no `core_data_ready` arrives in WAIT cycles 1..`TIMEOUT_CYCLES`, `error` rises on the next edge and `busy` falls on the same edge.

## Structure
- Package `des3_pkg`:
  - State enum `ctrl_state_t`.
  - `BLOCK_W = 64`.
  - Direction constants `DIR_ENC = 1'b0`, `DIR_DEC = 1'b1`.
- Single module, no sub-modules. The timeout counter is inline, with a next-state always_comb and a registered always_ff.

## Test plan
Bench core model: fixed latency 5, core_data_out = ~data_in in both directions.
- Encrypt CBC: `iv`=0123456789ABCDEF, P0=0, P1=FEDCBA9876543210 (`in_last` on P1) -> out FEDCBA9876543210 then FFFFFFFFFFFFFFFF with `out_last`; `busy` drops after the second handshake.
- Decrypt CBC: same `iv`, inputs FEDCBA9876543210, FFFFFFFFFFFFFFFF -> out 0000000000000000, FEDCBA9876543210; `core_mode`=3'b001 throughout.
- Backpressure: hold `out_ready`=0 for 20 cycles -> `out_valid`/`out_data` stable, `in_ready`=0, no second `core_enable`.
- Timeout: `TIMEOUT_CYCLES`=8, core never responds -> `error`=1 on WAIT cycle 9, state IDLE; a new `start` clears `error`.
- Stray/ignored events: `core_data_ready` pulsed in IDLE and ISSUE, and `start` pulsed in WAIT -> no output, chain unchanged, results match the encrypt vector.
- Reset mid-WAIT: drop `n_rst` two cycles after `core_enable` -> all outputs at reset values; a late core result produces no `out_valid`.
